calc_entry_sequencer: RTL and testbench

Control sequencer for the calculator front end. It debounces and edge-qualifies the one-hot digit keypad and the operator DIP switches, and walks a calculation through operand A, operator, operand B and equals. It then launches the shared arithmetic unit with a start/done handshake and requests LCD field refreshes from the display writer with a req/ack handshake. It sits between the board inputs and both the ALU and the LCD driver, and is the only block that issues ALU starts.

---
 rtl/calc_entry_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_sequencer.sv
// Calculator front-end sequencer: qualifies keypad/operator presses, steps A/op/B/equals,
// launches the ALU and requests LCD field refreshes.
module calc_entry_sequencer #(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key,
  input  logic [7:0]  op_sw,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic        alu_done,
  input  logic        alu_err,
  output logic        disp_req,
  output logic [2:0]  disp_slot,
  input  logic        disp_ack,
  output logic        busy,
  output logic [3:0]  state_led
);

  localparam int DCW = $clog2(DEBOUNCE + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_FAC     = 3'd6;
  localparam logic [2:0] SLOT_A     = 3'd0;
  localparam logic [2:0] SLOT_OP    = 3'd1;
  localparam logic [2:0] SLOT_B     = 3'd2;
  localparam logic [2:0] SLOT_RES   = 3'd3;
  localparam logic [2:0] SLOT_CLEAR = 3'd4;
  localparam logic [2:0] SLOT_ERR   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_GOT_A, S_GOT_OP, S_GOT_B, S_EXEC, S_SHOW, S_ERR
  } state_t;

  logic        w_key_acc;
  logic        w_op_acc;
  logic [11:0] w_key_val;
  logic [7:0]  w_op_val;

  // Group 0 is the keypad, group 1 the operator switches; same qualifier, different width.
  for (genvar gi = 0; gi < 2; gi++) begin : g_qual
    localparam int W = (gi == 0) ? 12 : 8;
    logic [W-1:0]   w_in;
    logic [W-1:0]   r_last;
    logic [W-1:0]   r_val;
    logic [DCW-1:0] r_press_cnt;
    logic [DCW-1:0] r_rel_cnt;
    logic [DCW-1:0] w_press_nx;
    logic [DCW-1:0] w_rel_nx;
    logic           r_armed;
    logic           r_acc;

    always_comb begin
      w_press_nx = '0;
      w_rel_nx   = '0;
      if (!$onehot(w_in))
        w_rel_nx = (r_rel_cnt == DCW'(DEBOUNCE)) ? r_rel_cnt : r_rel_cnt + 1'b1;
      else if (w_in == r_last)
        w_press_nx = (r_press_cnt == DCW'(DEBOUNCE)) ? r_press_cnt : r_press_cnt + 1'b1;
      else
        w_press_nx = DCW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_last      <= '0;
        r_val       <= '0;
        r_press_cnt <= '0;
        r_rel_cnt   <= '0;
        r_armed     <= 1'b1;
        r_acc       <= 1'b0;
      end else begin
        r_last      <= w_in;
        r_press_cnt <= w_press_nx;
        r_rel_cnt   <= w_rel_nx;
        r_acc       <= 1'b0;
        if (r_armed && (w_press_nx == DCW'(DEBOUNCE))) begin
          r_acc   <= 1'b1;
          r_armed <= 1'b0;
          r_val   <= w_in;
        end else if (w_rel_nx == DCW'(DEBOUNCE)) begin
          r_armed <= 1'b1;
        end
      end
    end

    if (gi == 0) begin : g_key
      assign w_in      = key;
      assign w_key_acc = r_acc;
      assign w_key_val = r_val;
    end else begin : g_op
      assign w_in     = op_sw;
      assign w_op_acc = r_acc;
      assign w_op_val = r_val;
    end
  end

  state_t         r_state, w_state_nx;
  logic [3:0]     r_a, r_b, w_a_nx, w_b_nx;
  logic [2:0]     r_op, w_op_nx;
  logic           r_disp_req, w_req_nx;
  logic [2:0]     r_disp_slot, w_slot_nx;
  logic           r_alu_start, w_start_nx;
  logic [TCW-1:0] r_tmo, w_tmo_nx;
  logic [3:0]     w_digit;
  logic [2:0]     w_opc;
  logic           w_clear, w_is_eq, w_digit_go, w_op_go;

  always_comb begin
    w_digit = '0;
    w_opc   = '0;
    for (int i = 2; i < 12; i++)
      if (w_key_val[i]) w_digit = 4'(11 - i);
    for (int i = 1; i < 8; i++)
      if (w_op_val[i]) w_opc = 3'(7 - i);
    w_clear    = w_key_acc && (w_key_val[1] || w_key_val[0]);
    w_is_eq    = w_op_val[0];
    w_digit_go = w_key_acc && !w_clear && !r_disp_req;
    // A key accept in the same cycle wins; the operator press is dropped.
    w_op_go    = w_op_acc && !w_key_acc && !r_disp_req;
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_req_nx   = r_disp_req;
    w_slot_nx  = r_disp_slot;
    w_start_nx = 1'b0;
    w_tmo_nx   = r_tmo;
    if (r_disp_req && disp_ack) w_req_nx = 1'b0;
    if (w_clear) begin
      w_a_nx = '0; w_b_nx = '0; w_state_nx = S_IDLE;
      w_req_nx = 1'b1; w_slot_nx = SLOT_CLEAR;
    end else begin
      case (r_state)
        S_IDLE: if (w_digit_go) begin
          w_a_nx = w_digit; w_req_nx = 1'b1; w_slot_nx = SLOT_A; w_state_nx = S_GOT_A;
        end
        S_GOT_A: if (w_digit_go) begin
          w_a_nx = w_digit; w_req_nx = 1'b1; w_slot_nx = SLOT_A;
        end else if (w_op_go && !w_is_eq) begin
          w_op_nx = w_opc; w_req_nx = 1'b1; w_slot_nx = SLOT_OP; w_state_nx = S_GOT_OP;
        end
        S_GOT_OP: if (w_digit_go) begin
          w_b_nx = w_digit; w_req_nx = 1'b1; w_slot_nx = SLOT_B; w_state_nx = S_GOT_B;
        end else if (w_op_go && !w_is_eq) begin
          w_op_nx = w_opc; w_req_nx = 1'b1; w_slot_nx = SLOT_OP;
        end else if (w_op_go && r_op == OP_FAC) begin
          w_b_nx = '0; w_state_nx = S_EXEC; w_start_nx = 1'b1; w_tmo_nx = '0;
        end
        S_GOT_B: if (w_digit_go) begin
          w_b_nx = w_digit; w_req_nx = 1'b1; w_slot_nx = SLOT_B;
        end else if (w_op_go && w_is_eq) begin
          w_state_nx = S_EXEC; w_start_nx = 1'b1; w_tmo_nx = '0;
        end
        S_EXEC: begin
          // A done coincident with the launch pulse belongs to nobody and is ignored.
          if (alu_done && !r_alu_start) begin
            w_req_nx   = 1'b1;
            w_slot_nx  = alu_err ? SLOT_ERR : SLOT_RES;
            w_state_nx = alu_err ? S_ERR : S_SHOW;
          end else if (r_tmo == TCW'(TIMEOUT - 1)) begin
            w_req_nx = 1'b1; w_slot_nx = SLOT_ERR; w_state_nx = S_ERR;
          end else begin
            w_tmo_nx = r_tmo + 1'b1;
          end
        end
        S_SHOW: if (r_disp_req && disp_ack) w_state_nx = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_disp_req  <= 1'b0;
      r_disp_slot <= '0;
      r_alu_start <= 1'b0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_a         <= w_a_nx;
      r_b         <= w_b_nx;
      r_op        <= w_op_nx;
      r_disp_req  <= w_req_nx;
      r_disp_slot <= w_slot_nx;
      r_alu_start <= w_start_nx;
      r_tmo       <= w_tmo_nx;
    end
  end

  assign alu_start = r_alu_start;
  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = (r_op == OP_FAC) ? 4'd0 : r_b;
  assign disp_req  = r_disp_req;
  assign disp_slot = r_disp_slot;
  assign busy      = (r_state == S_EXEC) || r_disp_req;

  always_comb begin
    case (r_state)
      S_IDLE:                      state_led = 4'b0001;
      S_GOT_A, S_GOT_OP, S_GOT_B:  state_led = 4'b0010;
      S_EXEC, S_SHOW:              state_led = 4'b0100;
      S_ERR:                       state_led = 4'b1000;
      default:                     state_led = 4'b0001;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer: scoreboards for display slots and ALU launches,
// with automatic ALU and display-writer responders.
module tb_calc_entry_sequencer;
  localparam int DEB = 3;
  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] key;
  logic [7:0]  op_sw;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [3:0]  alu_a, alu_b;
  logic        alu_done, alu_err;
  logic        disp_req;
  logic [2:0]  disp_slot;
  logic        disp_ack;
  logic        busy;
  logic [3:0]  state_led;

  calc_entry_sequencer #(.DEBOUNCE(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .key(key), .op_sw(op_sw),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_err(alu_err),
    .disp_req(disp_req), .disp_slot(disp_slot), .disp_ack(disp_ack),
    .busy(busy), .state_led(state_led)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_req = 0, n_start = 0, t_start = 0;
  int alu_dly = 1;
  logic alu_err_v = 1'b0;
  logic ack_en = 1'b1;
  logic [2:0]  exp_slot_q[$];
  logic [10:0] exp_alu_q[$];
  localparam logic [7:0]  EQ  = 8'h01;
  localparam logic [11:0] CLR = 12'h001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] kd(input int d);
    logic [11:0] v;
    v = 12'd1 << (11 - d);
    return v;
  endfunction

  function automatic logic [7:0] ko(input int c);
    logic [7:0] v;
    v = 8'd1 << (7 - c);
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every new display request and every launch is scored against the queues.
  initial begin
    logic prev_req, prev_start;
    logic [2:0] prev_slot;
    prev_req = 1'b0; prev_start = 1'b0; prev_slot = '0;
    forever begin
      @(negedge clk);
      if (disp_req && (!prev_req || disp_slot != prev_slot)) begin
        n_req++;
        check("req_expected", 32'(exp_slot_q.size() > 0), 1);
        if (exp_slot_q.size() > 0) check("disp_slot", 32'(disp_slot), 32'(exp_slot_q.pop_front()));
      end
      if (alu_start) begin
        n_start++;
        t_start = cyc;
        check("start_one_cycle", 32'(prev_start), 0);
        check("busy_in_exec", 32'(busy), 1);
        check("led_in_exec", 32'(state_led), 32'h4);
        check("alu_expected", 32'(exp_alu_q.size() > 0), 1);
        if (exp_alu_q.size() > 0) check("alu_op_a_b", 32'({alu_op, alu_a, alu_b}), 32'(exp_alu_q.pop_front()));
      end
      prev_req = disp_req; prev_slot = disp_slot; prev_start = alu_start;
    end
  end

  initial begin
    alu_done = 1'b0; alu_err = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start && alu_dly > 0) begin
        repeat (alu_dly) @(negedge clk);
        alu_done = 1'b1; alu_err = alu_err_v;
        @(negedge clk);
        alu_done = 1'b0; alu_err = 1'b0;
      end
    end
  end

  initial begin
    disp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (disp_req && ack_en) begin
        repeat (2) @(negedge clk);
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
      end
    end
  end

  task automatic wait_no_req();
    int t = 0;
    while (disp_req && t < 100) begin @(negedge clk); t++; end
    check("req_cleared", 32'(disp_req), 0);
  endtask

  task automatic wait_led(input logic [3:0] e, input string tag);
    int t = 0;
    while (state_led !== e && t < 200) begin @(negedge clk); t++; end
    check(tag, 32'(state_led), 32'(e));
  endtask

  task automatic press(input logic [11:0] k, input logic [7:0] o);
    wait_no_req();
    @(negedge clk);
    key = k; op_sw = o;
    repeat (DEB) @(negedge clk);
    key = '0; op_sw = '0;
    repeat (DEB + 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int r0, s0, t;
    key = '0; op_sw = '0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(state_led), 32'h1);
    check("rst_req", 32'(disp_req), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_outs", 32'({alu_op, alu_a, alu_b, disp_slot}), 0);
    rst = 1'b0;
    @(negedge clk);

    // 3 + 4 with done one cycle after the launch
    s0 = n_start;
    exp_slot_q.push_back(3'd0); press(kd(3), '0);
    exp_slot_q.push_back(3'd1); press('0, ko(0));
    exp_slot_q.push_back(3'd2); press(kd(4), '0);
    exp_alu_q.push_back({3'd0, 4'd3, 4'd4}); exp_slot_q.push_back(3'd3);
    press('0, EQ);
    wait_led(4'b0001, "add_idle");
    check("add_starts", 32'(n_start - s0), 1);
    wait_no_req();
    check("add_queue_empty", 32'(exp_slot_q.size()), 0);

    // bouncing digit 7, then a long hold
    r0 = n_req;
    for (int i = 0; i < 5; i++) begin
      key = kd(7); repeat (2) @(negedge clk);
      key = '0;    repeat (2) @(negedge clk);
    end
    check("bounce_no_accept", 32'(n_req - r0), 0);
    exp_slot_q.push_back(3'd0);
    key = kd(7);
    repeat (500) @(negedge clk);
    check("bounce_single_accept", 32'(n_req - r0), 1);
    key = '0;
    repeat (4) @(negedge clk);
    check("bounce_led", 32'(state_led), 32'h2);

    // factorial: equals in GOT_A is ignored, then 5 fac =
    exp_slot_q.push_back(3'd0); press(kd(5), '0);
    r0 = n_req;
    press('0, EQ);
    check("fac_eq_ignored_req", 32'(n_req - r0), 0);
    check("fac_eq_ignored_led", 32'(state_led), 32'h2);
    s0 = n_start;
    exp_slot_q.push_back(3'd1); press('0, ko(6));
    exp_alu_q.push_back({3'd6, 4'd5, 4'd0}); exp_slot_q.push_back(3'd3);
    press('0, EQ);
    wait_led(4'b0001, "fac_idle");
    check("fac_starts", 32'(n_start - s0), 1);

    // 9 / 0 returning an ALU error
    alu_err_v = 1'b1;
    exp_slot_q.push_back(3'd0); press(kd(9), '0);
    exp_slot_q.push_back(3'd1); press('0, ko(3));
    exp_slot_q.push_back(3'd2); press(kd(0), '0);
    exp_alu_q.push_back({3'd3, 4'd9, 4'd0}); exp_slot_q.push_back(3'd5);
    press('0, EQ);
    wait_led(4'b1000, "err_led");
    wait_no_req();
    check("err_busy", 32'(busy), 0);
    alu_err_v = 1'b0;
    exp_slot_q.push_back(3'd4); press(CLR, '0);
    wait_led(4'b0001, "err_clear_idle");

    // no done at all: ERR exactly TMO cycles after the launch
    alu_dly = 0;
    exp_slot_q.push_back(3'd0); press(kd(1), '0);
    exp_slot_q.push_back(3'd1); press('0, ko(0));
    exp_slot_q.push_back(3'd2); press(kd(2), '0);
    exp_alu_q.push_back({3'd0, 4'd1, 4'd2}); exp_slot_q.push_back(3'd5);
    press('0, EQ);
    wait_led(4'b1000, "tmo_led");
    check("tmo_cycles", 32'(cyc - t_start), TMO);
    exp_slot_q.push_back(3'd4); press(CLR, '0);
    wait_led(4'b0001, "tmo_clear_idle");

    // clear accepted two cycles after the launch; the late done must be ignored
    alu_dly = 6;
    exp_slot_q.push_back(3'd0); press(kd(2), '0);
    exp_slot_q.push_back(3'd1); press('0, ko(2));
    exp_slot_q.push_back(3'd2); press(kd(3), '0);
    exp_alu_q.push_back({3'd2, 4'd2, 4'd3}); exp_slot_q.push_back(3'd4);
    wait_no_req();
    s0 = n_start;
    @(negedge clk); op_sw = EQ;
    repeat (DEB) @(negedge clk);
    op_sw = '0; key = CLR;
    repeat (DEB) @(negedge clk);
    key = '0;
    repeat (15) @(negedge clk);
    check("clr_exec_starts", 32'(n_start - s0), 1);
    check("clr_exec_led", 32'(state_led), 32'h1);
    check("clr_exec_a", 32'(alu_a), 0);
    check("clr_exec_b", 32'(alu_b), 0);
    wait_no_req();
    check("clr_exec_queue_empty", 32'(exp_slot_q.size()), 0);
    alu_dly = 1;

    // digit 2 and sub accepted together in GOT_A: digit wins, op group stays disarmed
    exp_slot_q.push_back(3'd0); press(kd(1), '0);
    wait_no_req();
    r0 = n_req;
    exp_slot_q.push_back(3'd0);
    @(negedge clk); key = kd(2); op_sw = ko(1);
    repeat (DEB) @(negedge clk);
    key = '0;
    repeat (10) @(negedge clk);
    check("simul_one_req", 32'(n_req - r0), 1);
    check("simul_led", 32'(state_led), 32'h2);
    op_sw = '0;
    repeat (DEB + 1) @(negedge clk);
    exp_slot_q.push_back(3'd1); press('0, ko(0));
    exp_slot_q.push_back(3'd2); press(kd(5), '0);
    wait_no_req();
    ack_en = 1'b0;
    s0 = n_start;
    exp_alu_q.push_back({3'd0, 4'd2, 4'd5}); exp_slot_q.push_back(3'd3);
    press('0, EQ);
    t = 0;
    while (!disp_req && t < 50) begin @(negedge clk); t++; end
    check("pre_rst_req", 32'(disp_req), 1);

    // asynchronous reset with a request outstanding
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req", 32'(disp_req), 0);
    check("rst_mid_led", 32'(state_led), 32'h1);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    check("no_start_after_rst", 32'(n_start - s0), 1);
    check("slot_queue_empty", 32'(exp_slot_q.size()), 0);
    check("alu_queue_empty", 32'(exp_alu_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
